// File: rtl/sr_drv_pkg.sv
// Shared types and default parameters for the SR latch pulse driver.
package sr_drv_pkg;

  localparam int unsigned DB_CYCLES_DEF = 4;
  localparam int unsigned DB_CNT_W_DEF  = 8;
  localparam int unsigned PULSE_W_DEF   = 2;
  localparam int unsigned GAP_W_DEF     = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_SET   = 2'd1,
    REQ_RESET = 2'd2
  } req_t;

endpackage

// File: rtl/sr_pulse_driver_if.sv
// Latch-side bus: S/R drive toward the NOR latch and its Q fed back.
interface sr_pulse_driver_if;

  logic s_out;
  logic r_out;
  logic q_fb;

  modport master (output s_out, output r_out, input q_fb);
  modport slave  (input s_out, input r_out, output q_fb);

endinterface

// File: rtl/sr_debounce_ch.sv
// One request channel: 2-flop synchroniser, stability counter, rising-edge detect.
module sr_debounce_ch
  import sr_drv_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned DB_CNT_W  = DB_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise_c
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic                sync1;
  logic                sync2;
  logic                level;
  logic                level_d;
  logic [DB_CNT_W-1:0] cnt;

  // Level flips on the DB_CYCLES-th consecutive cycle that disagrees with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

  assign rise_c = level & ~level_d;

endmodule

// File: rtl/sr_pulse_driver.sv
// Turns debounced set/reset requests into non-overlapping S/R pulses for a NOR
// SR latch, tracks the expected Q and flags a sticky fault on Q mismatch.
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned DB_CNT_W  = DB_CNT_W_DEF,
  parameter int unsigned PULSE_W   = PULSE_W_DEF,
  parameter int unsigned GAP_W     = GAP_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_raw,
  input  logic                      reset_raw,
  sr_pulse_driver_if.master         latch,
  output logic                      busy,
  output logic                      conflict,
  output logic                      q_model,
  output logic                      fault
);

  localparam int unsigned WMAX   = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned WCNT_W = $clog2(WMAX + 1);
  localparam logic [WCNT_W-1:0] PULSE_LAST = WCNT_W'(PULSE_W - 1);
  localparam logic [WCNT_W-1:0] GAP_LAST   = WCNT_W'(GAP_W - 1);

  logic set_req;
  logic reset_req;

  sr_debounce_ch #(.DB_CYCLES(DB_CYCLES), .DB_CNT_W(DB_CNT_W)) u_set_ch (
    .clk    (clk),
    .rst    (rst),
    .raw    (set_raw),
    .rise_c (set_req)
  );

  sr_debounce_ch #(.DB_CYCLES(DB_CYCLES), .DB_CNT_W(DB_CNT_W)) u_reset_ch (
    .clk    (clk),
    .rst    (rst),
    .raw    (reset_raw),
    .rise_c (reset_req)
  );

  state_t              state, state_n;
  logic [WCNT_W-1:0]   wcnt, wcnt_n;
  req_t                pending, pending_n;
  logic                active_set, active_set_n;
  logic                valid, valid_n;
  logic                q_model_n;
  logic                fault_n;
  logic                conflict_n;
  logic                start_s;
  logic                start_r;
  logic                s_q;
  logic                r_q;

  // Next-state, pending and model/fault update.
  always_comb begin
    state_n      = state;
    wcnt_n       = wcnt;
    pending_n    = pending;
    active_set_n = active_set;
    valid_n      = valid;
    q_model_n    = q_model;
    fault_n      = fault;
    conflict_n   = set_req & reset_req;
    start_s      = 1'b0;
    start_r      = 1'b0;

    case (state)
      IDLE: begin
        if (set_req && !reset_req) begin
          start_s = 1'b1;
        end else if (reset_req && !set_req) begin
          start_r = 1'b1;
        end else if (!set_req && !reset_req) begin
          start_s = (pending == REQ_SET);
          start_r = (pending == REQ_RESET);
        end
        if (start_s || start_r) begin
          state_n      = start_s ? PULSE_S : PULSE_R;
          wcnt_n       = '0;
          active_set_n = start_s;
          pending_n    = REQ_NONE;
        end
        // Only reached a full GAP after the pulse, so Q has had time to settle.
        if (valid && (latch.q_fb != q_model)) begin
          fault_n = 1'b1;
        end
      end
      PULSE_S, PULSE_R: begin
        if (wcnt == PULSE_LAST) begin
          state_n   = GAP;
          wcnt_n    = '0;
          q_model_n = (state == PULSE_S);
          valid_n   = 1'b1;
        end else begin
          wcnt_n = wcnt + WCNT_W'(1);
        end
      end
      GAP: begin
        if (wcnt == GAP_LAST) begin
          state_n = IDLE;
          wcnt_n  = '0;
        end else begin
          wcnt_n = wcnt + WCNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // While busy, only the request opposite to the current pulse is kept.
    if ((state != IDLE) && (set_req != reset_req)) begin
      if (set_req && !active_set) begin
        pending_n = REQ_SET;
      end
      if (reset_req && active_set) begin
        pending_n = REQ_RESET;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      pending    <= REQ_NONE;
      active_set <= 1'b0;
      valid      <= 1'b0;
      q_model    <= 1'b0;
      fault      <= 1'b0;
      conflict   <= 1'b0;
      busy       <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
    end else begin
      state      <= state_n;
      wcnt       <= wcnt_n;
      pending    <= pending_n;
      active_set <= active_set_n;
      valid      <= valid_n;
      q_model    <= q_model_n;
      fault      <= fault_n;
      conflict   <= conflict_n;
      busy       <= (state_n != IDLE);
      s_q        <= (state_n == PULSE_S);
      r_q        <= (state_n == PULSE_R);
    end
  end

  assign latch.s_out = s_q;
  assign latch.r_out = r_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver with a behavioural NOR latch on the bus.
module tb_sr_pulse_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic set_raw = 1'b0;
  logic reset_raw = 1'b0;
  logic busy, conflict, q_model, fault;
  logic latch_q;
  logic fb_override = 1'b0;
  logic fb_val = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  sr_pulse_driver_if bus ();

  assign bus.q_fb = fb_override ? fb_val : latch_q;

  always @(posedge clk) begin
    if (rst)            latch_q <= 1'b0;
    else if (bus.s_out) latch_q <= 1'b1;
    else if (bus.r_out) latch_q <= 1'b0;
  end

  sr_pulse_driver #(
    .DB_CYCLES (4),
    .DB_CNT_W  (8),
    .PULSE_W   (2),
    .GAP_W     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .set_raw   (set_raw),
    .reset_raw (reset_raw),
    .latch     (bus),
    .busy      (busy),
    .conflict  (conflict),
    .q_model   (q_model),
    .fault     (fault)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock; afterwards outputs are sampled 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
    chk("s_and_r_overlap", bus.s_out & bus.r_out, 1'b0);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    set_raw     = 1'b0;
    reset_raw   = 1'b0;
    fb_override = 1'b0;
    rst         = 1'b1;
    steps(2);
    rst         = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_s_out", bus.s_out, 1'b0);
    chk("rst_r_out", bus.r_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_conflict", conflict, 1'b0);
    chk("rst_q_model", q_model, 1'b0);
    chk("rst_fault", fault, 1'b0);

    // Set latency: edge 0 samples set_raw, s_out rises on edge 6 for 2 cycles
    set_raw = 1'b1;
    steps(6);
    chk("lat_s_pre", bus.s_out, 1'b0);
    step();
    chk("lat_s_e6", bus.s_out, 1'b1);
    chk("lat_r_e6", bus.r_out, 1'b0);
    chk("lat_busy_e6", busy, 1'b1);
    step();
    chk("lat_s_e7", bus.s_out, 1'b1);
    chk("lat_q_e7", q_model, 1'b0);
    step();
    chk("lat_s_e8", bus.s_out, 1'b0);
    chk("lat_q_e8", q_model, 1'b1);
    chk("lat_busy_gap", busy, 1'b1);
    step();
    chk("lat_busy_e9", busy, 1'b0);
    steps(3);
    chk("lat_r_never", bus.r_out, 1'b0);
    chk("lat_fault", fault, 1'b0);
    chk("lat_q_hold", q_model, 1'b1);

    // Bouncing set line: high 2, low 2, never stable for 4 cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_raw = ((i % 4) < 2);
      step();
      chk("bounce_s", bus.s_out, 1'b0);
      chk("bounce_busy", busy, 1'b0);
    end
    set_raw = 1'b0;
    steps(8);
    chk("bounce_s_end", bus.s_out, 1'b0);
    chk("bounce_q", q_model, 1'b0);

    // Simultaneous set and reset: conflict pulse only
    do_reset();
    set_raw   = 1'b1;
    reset_raw = 1'b1;
    steps(6);
    chk("conf_pre", conflict, 1'b0);
    step();
    chk("conf_e6", conflict, 1'b1);
    chk("conf_busy", busy, 1'b0);
    chk("conf_s", bus.s_out, 1'b0);
    chk("conf_r", bus.r_out, 1'b0);
    step();
    chk("conf_e7", conflict, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("conf_s_after", bus.s_out, 1'b0);
      chk("conf_r_after", bus.r_out, 1'b0);
      chk("conf_busy_after", busy, 1'b0);
    end
    chk("conf_q", q_model, 1'b0);

    // Set then reset one cycle later: S pulse, gap, pending R pulse
    do_reset();
    set_raw = 1'b1;
    step();
    reset_raw = 1'b1;
    steps(5);
    step();
    chk("chain_s_e6", bus.s_out, 1'b1);
    chk("chain_r_e6", bus.r_out, 1'b0);
    step();
    chk("chain_s_e7", bus.s_out, 1'b1);
    step();
    chk("chain_s_e8", bus.s_out, 1'b0);
    chk("chain_r_e8", bus.r_out, 1'b0);
    chk("chain_q_e8", q_model, 1'b1);
    step();
    chk("chain_r_e9", bus.r_out, 1'b0);
    chk("chain_busy_e9", busy, 1'b0);
    step();
    chk("chain_r_e10", bus.r_out, 1'b1);
    chk("chain_s_e10", bus.s_out, 1'b0);
    step();
    chk("chain_r_e11", bus.r_out, 1'b1);
    chk("chain_q_e11", q_model, 1'b1);
    step();
    chk("chain_r_e12", bus.r_out, 1'b0);
    chk("chain_q_e12", q_model, 1'b0);
    chk("chain_busy_e12", busy, 1'b1);
    step();
    chk("chain_busy_e13", busy, 1'b0);
    steps(3);
    chk("chain_q_final", q_model, 1'b0);
    chk("chain_fault", fault, 1'b0);
    chk("chain_s_final", bus.s_out, 1'b0);

    // Latch Q stuck low after an S pulse: sticky fault, cleared by rst
    do_reset();
    fb_override = 1'b1;
    fb_val      = 1'b0;
    set_raw     = 1'b1;
    steps(9);
    chk("flt_q_e8", q_model, 1'b1);
    chk("flt_e8", fault, 1'b0);
    step();
    chk("flt_idle1", fault, 1'b0);
    chk("flt_busy_idle1", busy, 1'b0);
    step();
    chk("flt_idle2", fault, 1'b1);
    fb_override = 1'b0;
    set_raw     = 1'b0;
    steps(5);
    chk("flt_sticky", fault, 1'b1);
    rst = 1'b1;
    step();
    chk("flt_rst_clear", fault, 1'b0);
    chk("flt_rst_q", q_model, 1'b0);
    rst = 1'b0;

    // Reset during the first cycle of an S pulse truncates it
    do_reset();
    set_raw = 1'b1;
    steps(7);
    chk("trunc_s_on", bus.s_out, 1'b1);
    rst     = 1'b1;
    set_raw = 1'b0;
    step();
    chk("trunc_s_off", bus.s_out, 1'b0);
    chk("trunc_busy", busy, 1'b0);
    chk("trunc_q", q_model, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("trunc_s_after", bus.s_out, 1'b0);
      chk("trunc_r_after", bus.r_out, 1'b0);
      chk("trunc_busy_after", busy, 1'b0);
    end
    chk("trunc_q_after", q_model, 1'b0);
    chk("trunc_fault", fault, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
